// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b fetch sequencer.
package lc3b_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_ADDR = 3'd1,
        FETCH_MEM  = 3'd2,
        FETCH_IR   = 3'd3,
        DECODE     = 3'd4,
        EXEC       = 3'd5,
        HALTED     = 3'd6,
        FAULT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_RSV_A = 4'hA;
    localparam logic [3:0] OP_RSV_B = 4'hB;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_MEM_TMO = 2'd1;
    localparam logic [1:0] FLT_RSV_OP  = 2'd2;

    function automatic logic is_reserved(input logic [3:0] op);
        return (op == OP_RSV_A) || (op == OP_RSV_B);
    endfunction

endpackage

// File: rtl/lc3b_fetch_timer.sv
// Memory-wait timeout counter: counts FETCH_MEM cycles without mem_ready.
module lc3b_fetch_timer #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [TMO_W-1:0] o_count,
    output logic             o_expire
);

    logic [TMO_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expires on the MEM_TIMEOUT-th consecutive waiting cycle.
    assign o_expire = i_en && (r_count == TMO_W'(MEM_TIMEOUT - 1));
    assign o_count  = r_count;

endmodule

// File: rtl/lc3b_fetch_ctrl.sv
// LC-3b instruction-fetch sequencer: Moore FSM driving fetch load enables,
// opcode handoff to execute, run/halt, memory timeout and reserved-opcode faults.
module lc3b_fetch_ctrl
    import lc3b_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_halt_req,
    input  logic              i_mem_ready,
    input  logic [WORD_W-1:0] i_ir_value,
    input  logic              i_exec_done,
    output logic              o_ld_mar,
    output logic              o_ld_pc,
    output logic              o_mem_en,
    output logic              o_ld_mdr,
    output logic              o_ld_ir,
    output logic              o_op_valid,
    output logic [3:0]        o_opcode,
    output logic              o_busy,
    output logic              o_fault,
    output logic [1:0]        o_fault_code,
    output logic [15:0]       o_fetch_count,
    output logic [2:0]        o_dbg_state,
    output logic [TMO_W-1:0]  o_dbg_tmo_count
);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_opcode;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_fault_code_nxt;
    logic [15:0] r_fetch_count;
    logic        w_cnt_inc;
    logic        w_opcode_ld;
    logic [3:0]  w_ir_op;
    logic        w_tmo_en;
    logic        w_tmo_clr;
    logic        w_tmo_expire;
    logic        w_unused_ir;

    assign w_ir_op     = i_ir_value[WORD_W-1 -: 4];
    assign w_unused_ir = ^i_ir_value[WORD_W-5:0];

    // Counter runs only while waiting; mem_ready or expiry clears it on the way out.
    assign w_tmo_en  = (r_state == FETCH_MEM) && !i_mem_ready;
    assign w_tmo_clr = !w_tmo_en || w_tmo_expire;

    lc3b_fetch_timer #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_count  (o_dbg_tmo_count),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_opcode      <= 4'h0;
            r_fault_code  <= FLT_NONE;
            r_fetch_count <= 16'h0000;
        end else begin
            r_state      <= w_next_state;
            r_fault_code <= w_fault_code_nxt;
            if (w_opcode_ld) begin
                r_opcode <= w_ir_op;
            end
            if (w_cnt_inc) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_fault_code_nxt = r_fault_code;
        w_cnt_inc        = 1'b0;
        w_opcode_ld      = 1'b0;
        o_ld_mar         = 1'b0;
        o_ld_pc          = 1'b0;
        o_mem_en         = 1'b0;
        o_ld_mdr         = 1'b0;
        o_ld_ir          = 1'b0;
        o_op_valid       = 1'b0;
        o_opcode         = 4'h0;
        o_busy           = 1'b1;
        case (r_state)
            IDLE, HALTED: begin
                o_busy = 1'b0;
                if (i_run && !i_halt_req) begin
                    w_next_state = FETCH_ADDR;
                end
            end
            FETCH_ADDR: begin
                o_ld_mar     = 1'b1;
                o_ld_pc      = 1'b1;
                w_next_state = FETCH_MEM;
            end
            FETCH_MEM: begin
                // MDR loads every wait cycle; the mem_ready cycle's load is the one that sticks.
                o_mem_en = 1'b1;
                o_ld_mdr = 1'b1;
                if (i_mem_ready) begin
                    w_next_state = FETCH_IR;
                end else if (w_tmo_expire) begin
                    w_next_state     = FAULT;
                    w_fault_code_nxt = FLT_MEM_TMO;
                end
            end
            FETCH_IR: begin
                o_ld_ir      = 1'b1;
                w_next_state = DECODE;
            end
            DECODE: begin
                if (is_reserved(w_ir_op)) begin
                    w_next_state     = FAULT;
                    w_fault_code_nxt = FLT_RSV_OP;
                end else begin
                    w_next_state = EXEC;
                    w_cnt_inc    = 1'b1;
                    w_opcode_ld  = 1'b1;
                end
            end
            EXEC: begin
                o_op_valid = 1'b1;
                o_opcode   = r_opcode;
                if (i_exec_done) begin
                    w_next_state = i_halt_req ? HALTED : FETCH_ADDR;
                end
            end
            FAULT: begin
                o_busy = 1'b0;
            end
            default: begin
                o_busy       = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_fault       = (r_state == FAULT);
    assign o_fault_code  = r_fault_code;
    assign o_fetch_count = r_fetch_count;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/lc3b_fetch_ctrl.md
Name: lc3b_fetch_ctrl

Overview:
Instruction-fetch sequencer for the LC-3b datapath. Drives the load enables for MAR, PC, MDR and the instruction register (IR), and handshakes with memory. After the IR is loaded it hands the opcode to the execute unit. It waits for execute completion before fetching again, and handles run/halt, memory timeout and reserved opcodes.

Parameters:
WORD_W, 16, datapath/instruction width
TMO_W, 4, width of memory-wait timeout counter
MEM_TIMEOUT, 15, cycles in FETCH_MEM without mem_ready before FAULT (must fit TMO_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
run  in  1  start/resume fetching from IDLE or HALTED
halt_req  in  1  stop at next instruction boundary
mem_ready  in  1  memory read data valid this cycle
ir_value  in  WORD_W  current IR contents (for opcode decode)
exec_done  in  1  execute unit finished current instruction
ld_mar  out  1  MAR <- PC
ld_pc  out  1  PC <- PC+2
mem_en  out  1  memory read request
ld_mdr  out  1  MDR <- memory data
ld_ir  out  1  IR <- MDR
op_valid  out  1  opcode presented to execute unit
opcode  out  4  ir_value[15:12], held while op_valid
busy  out  1  state not IDLE/HALTED/FAULT
fault  out  1  sticky error flag
fault_code  out  2  0 none, 1 mem timeout, 2 reserved opcode
fetch_count  out  16  instructions decoded since reset, wraps

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; fetch_count 0. Reset is asynchronous, active-high, and aborts any state immediately.
- State register is updated on the rising clk edge.
- Control outputs are decoded from the state register only (Moore); no input-to-output combinational path.
- IDLE: if run=1 go to FETCH_ADDR, else stay.
- FETCH_ADDR: ld_mar=1, ld_pc=1 for exactly 1 cycle. Always go to FETCH_MEM.
- FETCH_MEM: mem_en=1.
  - mem_ready=1: ld_mdr=1 in the same cycle; go to FETCH_IR.
  - Otherwise the timeout counter increments.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0: go to FAULT, fault_code=1.
  - The counter clears on leaving FETCH_MEM.
  - mem_ready on the cycle the counter hits MEM_TIMEOUT counts as success; mem_ready wins.
- FETCH_IR: ld_ir=1 for 1 cycle. Go to DECODE.
- DECODE (1 cycle):
  - opcode = ir_value[15:12].
  - Opcode 4'hA or 4'hB (reserved): go to FAULT, fault_code=2; op_valid stays 0; fetch_count unchanged.
  - Otherwise: fetch_count increments (wraps 16'hFFFF -> 0) and state goes to EXEC.
- EXEC:
  - op_valid=1; opcode is held from the registered DECODE value, not live ir_value.
  - Wait for exec_done=1, then: if halt_req=1 go to HALTED, else go to FETCH_ADDR.
  - exec_done in the first EXEC cycle is honoured, so minimum EXEC length is 1 cycle.
- Minimum instruction period: 5 cycles (ADDR, MEM with immediate ready, IR, DECODE, EXEC).
- halt_req is sampled only on the exec_done cycle, or in IDLE where it blocks run.
- HALTED: busy=0. run=1 with halt_req=0 goes to FETCH_ADDR; PC is not reloaded, so fetch continues sequentially.
- FAULT: all load enables and mem_en are 0, op_valid=0, fault=1, fault_code held. Only reset exits FAULT; run is ignored.
- run and halt_req both 1 in IDLE/HALTED: halt wins; stay.
- exec_done or mem_ready outside their waiting state is ignored.
- At most one of ld_mar/ld_mdr/ld_ir is 1 in any cycle.

Decomposition:
- Shared package lc3b_pkg:
  - state enum (IDLE, FETCH_ADDR, FETCH_MEM, FETCH_IR, DECODE, EXEC, HALTED, FAULT)
  - opcode constants, including OP_RSV_A=4'hA and OP_RSV_B=4'hB
  - fault code constants FLT_NONE, FLT_MEM_TMO, FLT_RSV_OP
- One sub-module, lc3b_fetch_timer: the FETCH_MEM timeout counter with clear/enable/expire. The FSM, decode and counter stay in the top module.

Test Plan:
- Reset mid-FETCH_MEM (counter at 7) -> next cycle state IDLE, every output 0, counter 0, fetch_count 0.
- run=1; mem_ready asserted on the 1st FETCH_MEM cycle; ir_value=16'h1234; exec_done in the 1st EXEC cycle -> sequence is ld_mar+ld_pc, mem_en+ld_mdr, ld_ir, decode, op_valid with opcode=4'h1. Next FETCH_ADDR is 5 cycles after the first; fetch_count=1.
- mem_ready held 0 -> after 15 FETCH_MEM cycles: fault=1, fault_code=1. Then run pulsed -> stays FAULT. Reset -> IDLE.
- mem_ready arrives exactly on the 15th wait cycle -> no fault; goes to FETCH_IR.
- ir_value=16'hA000 at DECODE -> FAULT, fault_code=2, op_valid never 1, fetch_count unchanged.
- halt_req=1 at exec_done -> HALTED, busy=0. Then run=1 -> FETCH_ADDR. Separately, preload fetch_count=16'hFFFF via 65535 fast fetches (or force) -> the next decode gives 0.
